// File: rtl/l2_request_arbiter_if.sv
// l2_request_arbiter_if
//   Bundles the requester-side handshake and the L2 lookup/update bus of the
//   L2 request arbiter.
//   slave  : the arbiter (takes requests and L2 results, drives responses
//            and the L2 lookup fields)
//   master : the surroundings (requesters plus the L2 engine)
//   Signals:
//     req_valid[N_REQ], req_addr[32*N_REQ]     requester -> arbiter
//     resp_valid[N_REQ], resp_hit, resp_way    arbiter -> requester
//     l2_tag, l2_index, l2_block_offset,
//     l2_find_start                            arbiter -> L2
//     l2_found, l2_hit_way, l2_updated         L2 -> arbiter
interface l2_request_arbiter_if #(
    parameter int N_REQ           = 4,
    parameter int BLOCK_SIZE_BYTE = 16,
    parameter int SET_SIZE        = 64,
    parameter int WAY_W           = 4
);
    localparam int OFF_W = $clog2(BLOCK_SIZE_BYTE);
    localparam int IDX_W = $clog2(SET_SIZE);
    localparam int TAG_W = 32 - IDX_W - OFF_W;

    logic [N_REQ-1:0]    req_valid;
    logic [32*N_REQ-1:0] req_addr;
    logic [N_REQ-1:0]    resp_valid;
    logic                resp_hit;
    logic [WAY_W:0]      resp_way;

    logic [TAG_W-1:0]    l2_tag;
    logic [IDX_W-1:0]    l2_index;
    logic [OFF_W-1:0]    l2_block_offset;
    logic                l2_find_start;
    logic                l2_found;
    logic [WAY_W:0]      l2_hit_way;
    logic                l2_updated;

    modport slave (
        input  req_valid, req_addr, l2_found, l2_hit_way, l2_updated,
        output resp_valid, resp_hit, resp_way,
               l2_tag, l2_index, l2_block_offset, l2_find_start
    );

    modport master (
        output req_valid, req_addr, l2_found, l2_hit_way, l2_updated,
        input  resp_valid, resp_hit, resp_way,
               l2_tag, l2_index, l2_block_offset, l2_find_start
    );
endinterface

// File: rtl/l2_request_arbiter.sv
// l2_request_arbiter
//   Shares one L2 lookup/update engine among N_REQ L1-miss requesters.
//   A round-robin pick splits the winner's address into tag/index/offset,
//   pulses l2_find_start, waits for l2_updated (or a watchdog expiry) and
//   returns hit/way to the winner as a one-cycle resp_valid pulse.
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     bus (slave)       requester handshake and L2 bus, see the interface
//     grant_id[3]       current/last granted requester
//     busy              high from the cycle after grant through resp_valid
//     grant_count       16-bit per-requester grant counters, packed
//     hit_count         16-bit per-requester L2 hit counters, packed
//     timeout_err       sticky watchdog flag

// Per-requester statistics: wrapping grant and hit counters.
module l2_request_arbiter_lane (
    input  logic        clk,
    input  logic        reset,
    input  logic        grant_inc,
    input  logic        hit_inc,
    output logic [15:0] grant_cnt,
    output logic [15:0] hit_cnt
);
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt <= '0;
            hit_cnt   <= '0;
        end else begin
            if (grant_inc) grant_cnt <= grant_cnt + 16'd1;
            if (hit_inc)   hit_cnt   <= hit_cnt + 16'd1;
        end
    end
endmodule

module l2_request_arbiter #(
    parameter int N_REQ           = 4,
    parameter int BLOCK_SIZE_BYTE = 16,
    parameter int SET_SIZE        = 64,
    parameter int WAY_W           = 4,
    parameter int TIMEOUT         = 255
) (
    input  logic                clk,
    input  logic                reset,
    l2_request_arbiter_if.slave bus,
    output logic [2:0]          grant_id,
    output logic                busy,
    output logic [16*N_REQ-1:0] grant_count,
    output logic [16*N_REQ-1:0] hit_count,
    output logic                timeout_err
);
    localparam int OFF_W = $clog2(BLOCK_SIZE_BYTE);
    localparam int IDX_W = $clog2(SET_SIZE);
    localparam int TAG_W = 32 - IDX_W - OFF_W;
    localparam int SEL_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]                 state;
    logic [SEL_W-1:0]           rr_ptr;
    logic [SEL_W-1:0]           gsel;
    logic [SEL_W-1:0]           pick;
    logic [SEL_W-1:0]           rr_next;
    logic [SEL_W:0]             rr_sum;
    logic [SEL_W-1:0]           rr_k;
    logic                       any_req;
    logic [N_REQ-1:0][31:0]     addr_v;
    logic [31:0]                pick_addr;
    logic [TAG_W-1:0]           tag_q;
    logic [IDX_W-1:0]           idx_q;
    logic [OFF_W-1:0]           off_q;
    logic                       resp_hit_q;
    logic [WAY_W:0]             resp_way_q;
    logic [WD_W-1:0]            wd;
    logic [N_REQ-1:0]           resp_vec;
    logic [N_REQ-1:0]           grant_inc;
    logic [N_REQ-1:0]           hit_inc;

    assign addr_v    = bus.req_addr;
    assign any_req   = |bus.req_valid;
    assign pick_addr = addr_v[pick];

    // Round-robin pick: walk offsets from high to low so the requester
    // closest to rr_ptr (smallest offset) is the last, winning assignment.
    always_comb begin
        pick   = rr_ptr;
        rr_sum = '0;
        rr_k   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            rr_sum = {1'b0, rr_ptr} + (SEL_W+1)'(i);
            if (rr_sum >= (SEL_W+1)'(N_REQ)) rr_sum = rr_sum - (SEL_W+1)'(N_REQ);
            rr_k = rr_sum[SEL_W-1:0];
            if (bus.req_valid[rr_k]) pick = rr_k;
        end
    end

    assign rr_next = (gsel == SEL_W'(N_REQ - 1)) ? '0 : gsel + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            gsel        <= '0;
            tag_q       <= '0;
            idx_q       <= '0;
            off_q       <= '0;
            resp_hit_q  <= 1'b0;
            resp_way_q  <= '0;
            wd          <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        // Address fields are captured here and held until
                        // the next grant; later req_addr changes are ignored.
                        gsel  <= pick;
                        tag_q <= pick_addr[31:IDX_W+OFF_W];
                        idx_q <= pick_addr[IDX_W+OFF_W-1:OFF_W];
                        off_q <= pick_addr[OFF_W-1:0];
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wd    <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.l2_updated) begin
                        resp_hit_q <= bus.l2_found;
                        resp_way_q <= bus.l2_hit_way;
                        state      <= S_RESP;
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        // TIMEOUT WAIT cycles without l2_updated: report a
                        // miss with the out-of-range way so the requester
                        // is released.
                        timeout_err <= 1'b1;
                        resp_hit_q  <= 1'b0;
                        resp_way_q  <= {1'b1, {WAY_W{1'b0}}};
                        state       <= S_RESP;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                S_RESP: begin
                    rr_ptr <= rr_next;
                    state  <= S_GAP;
                end
                // L2 needs one cycle after updated before the next find_start.
                S_GAP:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < N_REQ; k++) begin : g_lane
        assign grant_inc[k] = (state == S_IDLE) && any_req && (pick == SEL_W'(k));
        assign hit_inc[k]   = (state == S_RESP) && resp_hit_q && (gsel == SEL_W'(k));
        assign resp_vec[k]  = (state == S_RESP) && (gsel == SEL_W'(k));

        l2_request_arbiter_lane u_lane (
            .clk       (clk),
            .reset     (reset),
            .grant_inc (grant_inc[k]),
            .hit_inc   (hit_inc[k]),
            .grant_cnt (grant_count[16*k +: 16]),
            .hit_cnt   (hit_count[16*k +: 16])
        );
    end

    assign bus.resp_valid      = resp_vec;
    assign bus.resp_hit        = resp_hit_q;
    assign bus.resp_way        = resp_way_q;
    assign bus.l2_tag          = tag_q;
    assign bus.l2_index        = idx_q;
    assign bus.l2_block_offset = off_q;
    assign bus.l2_find_start   = (state == S_ISSUE);
    assign busy                = (state == S_ISSUE) || (state == S_WAIT) || (state == S_RESP);
    assign grant_id            = 3'(gsel);
endmodule
